// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display blocks: active-high segment
// patterns (bit0=a .. bit6=g), slot phase type and an index-width helper.
package seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b1111100;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b0111001;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b1011110;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b1110001;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  // Guard cycles keep every select off while the segment bus settles.
  typedef enum logic {
    PH_GUARD  = 1'b0,
    PH_ACTIVE = 1'b1
  } slot_phase_e;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_pattern_lut.sv
// Combinational 4-bit code to active-high seven-segment pattern.
// Codes 10..15 decode to A..F only when HEX_MODE is set, otherwise blank.
module seg_pattern_lut
  import seg_pkg::*;
#(
  parameter bit HEX_MODE = 1'b0
) (
  input  logic [3:0]       code_i,
  output logic [SEG_W-1:0] pattern_o
);

  always_comb begin
    case (code_i)
      4'h0:    pattern_o = SEG_0;
      4'h1:    pattern_o = SEG_1;
      4'h2:    pattern_o = SEG_2;
      4'h3:    pattern_o = SEG_3;
      4'h4:    pattern_o = SEG_4;
      4'h5:    pattern_o = SEG_5;
      4'h6:    pattern_o = SEG_6;
      4'h7:    pattern_o = SEG_7;
      4'h8:    pattern_o = SEG_8;
      4'h9:    pattern_o = SEG_9;
      4'hA:    pattern_o = HEX_MODE ? SEG_A : SEG_BLANK;
      4'hB:    pattern_o = HEX_MODE ? SEG_B : SEG_BLANK;
      4'hC:    pattern_o = HEX_MODE ? SEG_C : SEG_BLANK;
      4'hD:    pattern_o = HEX_MODE ? SEG_D : SEG_BLANK;
      4'hE:    pattern_o = HEX_MODE ? SEG_E : SEG_BLANK;
      default: pattern_o = HEX_MODE ? SEG_F : SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed N-digit seven-segment driver: shadow register, slot counter and
// digit index, leading-zero mask, and registered segment/dp/select outputs.
module sevenseg_scan_driver
  import seg_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2,
  parameter int HEX_MODE    = 0,
  parameter int BLANK_LZ    = 1,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  enable,
  output logic [SEG_W-1:0]      segments,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   digit_sel
);

  localparam int IDX_W = idx_width(N_DIGITS);
  localparam int CNT_W = idx_width(REFRESH_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  // XOR masks: the inactive level of each output, which also converts an
  // active-high pattern to the pin polarity.
  localparam logic                POL     = (ACTIVE_LOW != 0);
  localparam logic [SEG_W-1:0]    SEG_OFF = {SEG_W{POL}};
  localparam logic [N_DIGITS-1:0] SEL_OFF = {N_DIGITS{POL}};

  logic [4*N_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [N_DIGITS-1:0]   shadow_dp_q,  shadow_dp_d;
  logic [CNT_W-1:0]      cnt_q,        cnt_d;
  logic [IDX_W-1:0]      idx_q,        idx_d;
  logic [SEG_W-1:0]      seg_q,        seg_d;
  logic                  dp_q,         dp_d;
  logic [N_DIGITS-1:0]   sel_q,        sel_d;

  logic [N_DIGITS-1:0] lz_mask;
  logic [N_DIGITS-1:0] sel_hot;
  logic [3:0]          cur_code;
  logic                cur_dp;
  logic                cur_blank;
  logic [SEG_W-1:0]    lut_pattern;
  logic [SEG_W-1:0]    disp_pattern;
  slot_phase_e         phase;

  // Digit i>0 is blank while it and everything above it are zero.
  always_comb begin
    logic all_zero;
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero & (shadow_val_q[4*i +: 4] == 4'h0);
      lz_mask[i] = all_zero & (BLANK_LZ != 0);
    end
  end

  always_comb begin
    cur_code  = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    sel_hot   = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_code   = shadow_val_q[4*i +: 4];
        cur_dp     = shadow_dp_q[i];
        cur_blank  = lz_mask[i];
        sel_hot[i] = 1'b1;
      end
    end
  end

  seg_pattern_lut #(
    .HEX_MODE (HEX_MODE != 0)
  ) u_lut (
    .code_i    (cur_code),
    .pattern_o (lut_pattern)
  );

  assign phase        = (cnt_q >= CNT_GUARD) ? PH_ACTIVE : PH_GUARD;
  assign disp_pattern = cur_blank ? SEG_BLANK : lut_pattern;

  always_comb begin
    shadow_val_d = load ? value : shadow_val_q;
    shadow_dp_d  = load ? dp_in : shadow_dp_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    seg_d        = SEG_OFF;
    dp_d         = POL;
    sel_d        = SEL_OFF;

    if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      // Segments and dp carry the digit through its guard cycles; only the
      // select waits for the active phase.
      seg_d = disp_pattern ^ SEG_OFF;
      dp_d  = cur_dp ^ POL;
      sel_d = ((phase == PH_ACTIVE) ? sel_hot : '0) ^ SEL_OFF;
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= POL;
      sel_q        <= SEL_OFF;
    end else begin
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      sel_q        <= sel_d;
    end
  end

  assign segments  = seg_q;
  assign dp        = dp_q;
  assign digit_sel = sel_q;

endmodule
